// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle two's-complement subtractor: diff = a - b - bin, one 4-bit CLA group per clock.
// Optional zero-result flag enabled by defining SUB_ZERO_FLAG_EN.
module nibble_serial_subtractor #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
`ifdef SUB_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             ovf
);

    localparam int unsigned N    = WIDTH / 4;
    localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned MSB  = WIDTH - 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
        $error("nibble_serial_subtractor: WIDTH must be a multiple of 4 and at least 4");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] nb_q, nb_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

`ifdef SUB_ZERO_FLAG_EN
    logic             nz_q, nz_d;
    logic             zero_q, zero_d;
`endif

    logic [3:0]       grp_a, grp_nb, grp_s;
    logic             grp_c4;

    // Lookahead carries for one group: every carry is a flat sum of products of g, p and c0.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic c0);
        logic [3:0] p, g;
        logic [4:0] c;
        p    = x ^ y;
        g    = x & y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], p ^ c[3:0]};
    endfunction

    always_comb begin
        grp_a            = a_q[{cnt_q, 2'b00} +: 4];
        grp_nb           = nb_q[{cnt_q, 2'b00} +: 4];
        {grp_c4, grp_s}  = cla4(grp_a, grp_nb, carry_q);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        nb_d    = nb_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
`ifdef SUB_ZERO_FLAG_EN
        nz_d    = nz_q;
        zero_d  = zero_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    nb_d    = ~b;
                    carry_d = ~bin;
                    cnt_d   = '0;
`ifdef SUB_ZERO_FLAG_EN
                    nz_d    = 1'b0;
`endif
                    state_d = StRun;
                end
            end
            StRun: begin
                diff_d[{cnt_q, 2'b00} +: 4] = grp_s;
                carry_d = grp_c4;
                cnt_d   = cnt_q + 1'b1;
`ifdef SUB_ZERO_FLAG_EN
                nz_d    = nz_q | (|grp_s);
`endif
                if (cnt_q == LAST) begin
                    // Carry out of a + ~b + ~bin is the inverted borrow.
                    bout_d  = ~grp_c4;
                    // nb holds ~b, so equal MSBs here mean a and b had different signs.
                    ovf_d   = (a_q[MSB] == nb_q[MSB]) & (grp_s[3] != a_q[MSB]);
`ifdef SUB_ZERO_FLAG_EN
                    zero_d  = ~(nz_q | (|grp_s));
`endif
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            nb_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SUB_ZERO_FLAG_EN
            nz_q    <= 1'b0;
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            nb_q    <= nb_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
`ifdef SUB_ZERO_FLAG_EN
            nz_q    <= nz_d;
            zero_q  <= zero_d;
`endif
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;
`ifdef SUB_ZERO_FLAG_EN
    assign zero = zero_q;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor (WIDTH=16): vector table, random ops
// against an arithmetic reference, and handshake/reset corner sequences.
module tb_nibble_serial_subtractor;

    localparam int unsigned W = 16;
    localparam int unsigned N = W / 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
`ifdef SUB_ZERO_FLAG_EN
    logic         zero;
`endif

    int errors = 0;
    int checks = 0;

    nibble_serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
`ifdef SUB_ZERO_FLAG_EN
        .zero  (zero),
`endif
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        logic         zero;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain wide subtraction; bit W of the result is the unsigned borrow.
    function automatic logic [W+2:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic bi);
        logic [W:0]   full;
        logic [W-1:0] d;
        logic         o;
        full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
        d    = full[W-1:0];
        o    = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
        return {(d == '0), o, full[W], d};
    endfunction

    function automatic logic cur_zero();
`ifdef SUB_ZERO_FLAG_EN
        return zero;
`else
        return 1'b0;
`endif
    endfunction

    // One full operation; scrambles operand inputs after start to prove they were latched.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                         output logic [W-1:0] rd, output logic rbo, output logic rov,
                         output logic rz);
        int busy_cycles;
        logic got;
        busy_cycles = 0;
        got = 1'b0;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_v; bin = tbin;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        for (int i = 0; i < 20 && !got; i++) begin
            if (done) got = 1'b1;
            else begin
                if (busy) busy_cycles++;
                @(negedge clk);
            end
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("latency", busy_cycles, N);
        rd = diff; rbo = bout; rov = ovf; rz = cur_zero();
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("diff_hold", 32'(diff), 32'(rd));
    endtask

    vec_t vecs[8];

    initial begin
        logic [W-1:0] rd;
        logic         rbo, rov, rz;
        logic [W+2:0] exp;
        int           pulses;
        int           t_first, t_second;

        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_diff", 32'(diff), 32'd0);
        chk("reset_bout_ovf", {30'd0, bout, ovf}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].bin, rd, rbo, rov, rz);
            chk($sformatf("vec%0d_diff", i), 32'(rd), 32'(vecs[i].diff));
            chk($sformatf("vec%0d_bout", i), 32'(rbo), 32'(vecs[i].bout));
            chk($sformatf("vec%0d_ovf", i), 32'(rov), 32'(vecs[i].ovf));
`ifdef SUB_ZERO_FLAG_EN
            chk($sformatf("vec%0d_zero", i), 32'(rz), 32'(vecs[i].zero));
`endif
        end

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic         rbi;
            ra = W'($urandom); rb = (i % 8 == 0) ? ra : W'($urandom); rbi = 1'($urandom);
            exp = ref_sub(ra, rb, rbi);
            do_op(ra, rb, rbi, rd, rbo, rov, rz);
            chk($sformatf("rnd%0d_diff", i), 32'(rd), 32'(exp[W-1:0]));
            chk($sformatf("rnd%0d_bout", i), 32'(rbo), 32'(exp[W]));
            chk($sformatf("rnd%0d_ovf", i), 32'(rov), 32'(exp[W+1]));
`ifdef SUB_ZERO_FLAG_EN
            chk($sformatf("rnd%0d_zero", i), 32'(rz), 32'(exp[W+2]));
`endif
        end

        // start re-pulsed with new operands while busy and during done: ignored.
        @(negedge clk);
        start = 1'b1; a = 16'h1234; b = 16'h0234; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 16'hFFFF; b = 16'h0001; bin = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                pulses++;
                chk("ignore_start_diff", 32'(diff), 32'h1000);
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("ignore_start_pulses", pulses, 1);
        chk("ignore_start_idle", 32'(busy), 32'd0);

        // Async reset mid-operation aborts with no done pulse.
        @(negedge clk);
        start = 1'b1; a = 16'hFFFF; b = 16'h0000; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_flags", {30'd0, bout, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        chk("abort_no_done", pulses, 0);
        do_op(16'h0100, 16'h0001, 1'b0, rd, rbo, rov, rz);
        chk("after_abort_diff", 32'(rd), 32'h00FF);

        // start held high: back-to-back operations, one every N+2 cycles.
        @(negedge clk);
        start = 1'b1; a = 16'h0F0F; b = 16'h00FF; bin = 1'b0;
        pulses = 0; t_first = 0; t_second = 0;
        for (int i = 0; i < 30 && pulses < 2; i++) begin
            if (done) begin
                pulses++;
                chk("held_start_diff", 32'(diff), 32'h0E10);
                if (pulses == 1) t_first = i;
                else begin
                    t_second = i;
                    start = 1'b0;
                end
            end
            @(negedge clk);
        end
        chk("held_start_pulses", pulses, 2);
        chk("held_start_gap", t_second - t_first, N + 2);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
